axis_register_fifo: RTL and testbench

//  Parametrised AXI4-Stream register slice: DEPTH-entry circular buffer, full throughput, occupancy and

---
 rtl/axis_if.sv | 18 +
 rtl/axis_register_fifo.sv | 118 +++++++++++
 tb/tb_axis_register_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axis_if.sv
// AXI4-Stream bundle shared by the register FIFO and its neighbours.
//   master modport: drives tdata/tkeep/tvalid/tlast/tuser, samples tready
//   slave  modport: samples tdata/tkeep/tvalid/tlast/tuser, drives tready
interface axis_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_register_fifo.sv
// AXI4-Stream register FIFO: DEPTH-entry circular buffer with full throughput,
// occupancy count, registered almost-full flag and a synchronous flush.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-high (clears pointers, count, storage)
//   flush        synchronous clear of buffer contents, active-high
//   s_axis       AXI4-Stream input  (axis_if.slave)
//   m_axis       AXI4-Stream output (axis_if.master)
//   count        current occupancy, 0..DEPTH
//   almost_full  registered, high when count >= AFULL_LEVEL
module axis_register_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter bit LAST_ENABLE = 1'b1,
    parameter bit USER_ENABLE = 1'b1,
    parameter int USER_WIDTH  = 1,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    axis_if.slave         s_axis,
    axis_if.master        m_axis,
    output logic [CW-1:0] count,
    output logic          almost_full
);
    localparam int PW = $clog2(DEPTH);
    // Entry layout, MSB first: data | keep | last | user
    localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          almost_full_reg;
    logic          s_ready, m_valid;
    logic          push, pop;
    logic [EW-1:0] in_word, out_word;
    logic [EW-1:0] entry_q [DEPTH];

    // Handshake flags depend only on registered state and flush, so there is
    // no combinational path between the two sides of the buffer.
    assign s_ready = (count_reg != CW'(DEPTH)) && !flush;
    assign m_valid = (count_reg != '0) && !flush;
    assign push    = s_axis.tvalid && s_ready;
    assign pop     = m_valid && m_axis.tready;

    // Disabled sideband fields are stored as zero so synthesis trims them.
    assign in_word = {s_axis.tdata,
                      KEEP_ENABLE ? s_axis.tkeep : {KEEP_WIDTH{1'b0}},
                      LAST_ENABLE ? s_axis.tlast : 1'b0,
                      USER_ENABLE ? s_axis.tuser : {USER_WIDTH{1'b0}}};

    // Storage entries, cleared on reset so the output payload reads zero.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [EW-1:0] entry_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (push && (wr_ptr_reg == PW'(gi))) begin
                entry_reg <= in_word;
            end
        end
        assign entry_q[gi] = entry_reg;
    end

    // Explicit wrap at DEPTH-1 so non-power-of-2 depths work.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            almost_full_reg <= 1'b0;
        end else if (flush) begin
            // Stored payload is left as-is; emptying the pointers is enough.
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            almost_full_reg <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            almost_full_reg <= (count_next >= CW'(AFULL_LEVEL));
        end
    end

    assign out_word = entry_q[rd_ptr_reg];

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = out_word[EW-1 -: DATA_WIDTH];
    assign m_axis.tkeep  = KEEP_ENABLE ? out_word[USER_WIDTH+1 +: KEEP_WIDTH] : {KEEP_WIDTH{1'b1}};
    assign m_axis.tlast  = LAST_ENABLE ? out_word[USER_WIDTH] : 1'b1;
    assign m_axis.tuser  = USER_ENABLE ? out_word[USER_WIDTH-1:0] : {USER_WIDTH{1'b0}};

    assign count       = count_reg;
    assign almost_full = almost_full_reg;
endmodule

// File: tb/tb_axis_register_fifo.sv
// Bench for axis_register_fifo: three instances (DEPTH 4, 5, 3) share one
// stimulus; sel picks the instance whose outputs are checked against a
// queue-based model of contents, handshake flags, count and almost_full.
module tb_axis_register_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tuser;
    logic       m_tready;

    logic [7:0] o_tdata  [3];
    logic       o_tkeep  [3];
    logic       o_mvalid [3];
    logic       o_sready [3];
    logic       o_tlast  [3];
    logic       o_tuser  [3];
    logic [2:0] o_count  [3];
    logic       o_af     [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int D = (gi == 0) ? 4 : (gi == 1) ? 5 : 3;
        logic [$clog2(D+1)-1:0] cnt;
        logic                   af;
        axis_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1)) s_if ();
        axis_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1)) m_if ();

        assign s_if.tdata  = s_tdata;
        assign s_if.tkeep  = 1'b1;
        assign s_if.tvalid = s_tvalid;
        assign s_if.tlast  = s_tlast;
        assign s_if.tuser  = s_tuser;
        assign m_if.tready = m_tready;

        axis_register_fifo #(.DATA_WIDTH(8), .DEPTH(D)) dut (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .s_axis      (s_if.slave),
            .m_axis      (m_if.master),
            .count       (cnt),
            .almost_full (af)
        );

        assign o_tdata[gi]  = m_if.tdata;
        assign o_tkeep[gi]  = m_if.tkeep[0];
        assign o_mvalid[gi] = m_if.tvalid;
        assign o_sready[gi] = s_if.tready;
        assign o_tlast[gi]  = m_if.tlast;
        assign o_tuser[gi]  = m_if.tuser[0];
        assign o_count[gi]  = 3'(cnt);
        assign o_af[gi]     = af;
    end

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } item_t;

    item_t      q[$];
    int         sel;
    int         dep;
    int         n_total = 0;
    int         n_bad   = 0;
    bit         stall_prev;
    logic [7:0] held;
    bit         last_push;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h (depth=%0d t=%0t)", tag, got, exp, dep, $time);
        end
    endtask

    // One clock cycle: drive inputs, check the selected instance against the
    // model, update the model, advance to 1ns after the next rising edge.
    task automatic beat(input bit v, input logic [7:0] d, input bit l, input bit u,
                        input bit rdy, input bit fl);
        bit    exp_rdy, exp_vld, push, pop;
        item_t it;
        s_tvalid = v; s_tdata = d; s_tlast = l; s_tuser = u;
        m_tready = rdy; flush = fl;
        #1;
        exp_rdy = (q.size() != dep) && !fl;
        exp_vld = (q.size() != 0) && !fl;
        chk("count",    32'(o_count[sel]), 32'(q.size()));
        chk("s_tready", 32'(o_sready[sel]), 32'(exp_rdy));
        chk("m_tvalid", 32'(o_mvalid[sel]), 32'(exp_vld));
        chk("afull",    32'(o_af[sel]), 32'(q.size() >= dep - 1));
        if (stall_prev && !fl) chk("hold_data", 32'(o_tdata[sel]), 32'(held));
        pop  = exp_vld && rdy;
        push = v && exp_rdy;
        if (pop) begin
            it = q.pop_front();
            chk("data", 32'(o_tdata[sel]), 32'(it.d));
            chk("last", 32'(o_tlast[sel]), 32'(it.l));
            chk("user", 32'(o_tuser[sel]), 32'(it.u));
        end
        if (push) q.push_back('{d: d, l: l, u: u});
        last_push  = push;
        stall_prev = exp_vld && !rdy;
        held       = o_tdata[sel];
        if (fl) begin
            q.delete();
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * dep + 8; k++) beat(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Async reset asserted between edges; outputs must clear immediately.
    task automatic do_reset(input int s);
        rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0; flush = 1'b0;
        #1;
        chk("rst_count",  32'(o_count[sel]), 32'd0);
        chk("rst_mvalid", 32'(o_mvalid[sel]), 32'd0);
        chk("rst_afull",  32'(o_af[sel]), 32'd0);
        chk("rst_tdata",  32'(o_tdata[sel]), 32'd0);
        chk("rst_tkeep",  32'(o_tkeep[sel]), 32'd1);
        q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sel = s;
        dep = (s == 0) ? 4 : (s == 1) ? 5 : 3;
    endtask

    initial begin
        int widx;
        rst = 1'b1; flush = 1'b0; s_tdata = '0; s_tvalid = 1'b0;
        s_tlast = 1'b0; s_tuser = 1'b0; m_tready = 1'b0;
        sel = 0; dep = 4; stall_prev = 1'b0; held = '0; last_push = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-stream with three words held
        for (int i = 0; i < 3; i++) beat(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset(0);
        beat(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back streaming at DEPTH=4
        for (int i = 1; i <= 64; i++) beat(1'b1, 8'(i), i[0], i[1], 1'b1, 1'b0);
        drain();

        // Fill/drain at DEPTH=5: seven offered, five accepted
        do_reset(1);
        for (int i = 0; i < 7; i++) beat(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(o_count[sel]), 32'd5);
        drain();

        // Full with a single pop, then push into the freed slot
        do_reset(0);
        for (int i = 0; i < 4; i++) beat(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 1'b0);
        beat(1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 1'b0);
        beat(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Flush with a valid word offered, then 0xA5 must come out first
        for (int i = 0; i < 3; i++) beat(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        // Randomised valid/ready at DEPTH=3
        do_reset(2);
        widx = 0;
        for (int n = 0; n < 400; n++) begin
            beat(1'($urandom_range(0, 1)), 8'(widx), (widx % 7) == 6, widx[0],
                 $urandom_range(0, 9) < 3, 1'b0);
            if (last_push) widx++;
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
